// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and byte-level round primitives
// (S-box, Sub_Bytes, Shift_Rows, Mix_Columns) used by the iterative controller.
package aes_pkg;

  localparam int unsigned AES_W  = 128;
  localparam int unsigned AES_NR = 10;

  typedef logic [0:AES_W-1] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_t;

  // Forward S-box, byte 0x00 in the leftmost position.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  // Round constants for rounds 1..10; anything else yields 0.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t o;
    for (int unsigned i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t     o;
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// Combinational AES-128 key schedule step: next round key from the current
// round key and the round constant.
module aes128_key_step
  import aes_pkg::*;
(
  input  block_t     key,
  input  logic [7:0] rcon,
  output block_t     next_key
);

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] temp;
  logic [0:31] n0, n1, n2, n3;

  assign w0 = key[0:31];
  assign w1 = key[32:63];
  assign w2 = key[64:95];
  assign w3 = key[96:127];

  // SubWord(RotWord(w3)) with the round constant folded into the first byte.
  assign temp = {sbox(w3[8:15]) ^ rcon, sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_iter_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on
// the fly, valid/ready handshakes on both the block input and ciphertext output.
module aes128_iter_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [0:127] PLAINTEXT,
  input  logic [0:127] KEY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [0:127] CIPHERTEXT,
  output logic         BUSY
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes128_iter_round_ctrl: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  ctrl_state_t st, st_nxt;
  logic [3:0]  rnd;
  block_t      state_reg;
  block_t      key_reg;

  block_t      sr, mc, rk, round_out;
  logic [7:0]  rc;
  logic        rnd_ok;
  logic        last_rnd;

  assign rnd_ok   = (rnd != 4'd0) && (rnd <= LAST_RND);
  assign last_rnd = (rnd == LAST_RND);
  assign rc       = rcon_of(rnd);

  aes128_key_step u_key_step (
    .key      (key_reg),
    .rcon     (rc),
    .next_key (rk)
  );

  // Final round skips Mix_Columns.
  assign sr        = shift_rows(sub_bytes(state_reg));
  assign mc        = mix_columns(sr);
  assign round_out = (last_rnd ? sr : mc) ^ rk;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st        <= ST_IDLE;
      rnd       <= '0;
      state_reg <= '0;
      key_reg   <= '0;
    end else begin
      st <= st_nxt;
      case (st)
        ST_IDLE: begin
          if (IN_VALID) begin
            state_reg <= PLAINTEXT ^ KEY;
            key_reg   <= KEY;
            rnd       <= 4'd1;
          end
        end
        ST_ROUND: begin
          if (rnd_ok) begin
            state_reg <= round_out;
            key_reg   <= rk;
            rnd       <= last_rnd ? 4'd0 : rnd + 4'd1;
          end else begin
            rnd <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nxt    = st;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    case (st)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) st_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        BUSY = 1'b1;
        if (!rnd_ok)      st_nxt = ST_IDLE;
        else if (last_rnd) st_nxt = ST_DONE;
      end
      ST_DONE: begin
        BUSY      = 1'b1;
        OUT_VALID = 1'b1;
        if (OUT_READY) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign CIPHERTEXT = state_reg;

endmodule

// File: tb/tb_aes128_iter_round_ctrl.sv
// Scoreboard bench for aes128_iter_round_ctrl using FIPS-197 known-answer vectors.
module tb_aes128_iter_round_ctrl;

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [0:127] PLAINTEXT;
  logic [0:127] KEY;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [0:127] CIPHERTEXT;
  logic         BUSY;

  int checks = 0;
  int errors = 0;
  logic [0:127] exp_q[$];

  always #5 CLK = ~CLK;

  aes128_iter_round_ctrl #(.NR(10)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .PLAINTEXT  (PLAINTEXT),
    .KEY        (KEY),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .CIPHERTEXT (CIPHERTEXT),
    .BUSY       (BUSY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for IN_READY, presents one block for a single edge and
  // records the expected ciphertext on the scoreboard.
  task automatic send_block(input logic [0:127] pt, input logic [0:127] key,
                            input logic [0:127] exp, output bit ok);
    int n = 0;
    while (!IN_READY && n < 40) begin
      tick();
      n++;
    end
    ok = IN_READY;
    if (ok) begin
      PLAINTEXT = pt;
      KEY       = key;
      IN_VALID  = 1'b1;
      exp_q.push_back(exp);
      tick();
      IN_VALID  = 1'b0;
    end
  endtask

  // Edges from now until OUT_VALID is seen; -1 when the bound expires.
  task automatic wait_out(output int n);
    n = 0;
    while (!OUT_VALID && n < 40) begin
      tick();
      n++;
    end
    if (!OUT_VALID) n = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    PLAINTEXT = '0; KEY = '0;
    tick();
    tick();
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b required 1 0 0", IN_READY, OUT_VALID, BUSY);
    end
    checks++;
    if (CIPHERTEXT !== 128'h0) begin
      errors++;
      $display("FAIL reset_ct: got %h required 0", CIPHERTEXT);
    end
    RST = 1'b0;
  endtask

  task automatic test_c1();
    bit ok;
    int n;
    logic [0:127] e;
    send_block(C1_PT, C1_KEY, C1_CT, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL c1_accept: in_ready=%b required 1", IN_READY); end
    wait_out(n);
    // Ten edges after the accept edge: OUT_VALID in the 11th cycle from accept.
    checks++;
    if (n != 10) begin errors++; $display("FAIL c1_latency: got %0d edges required 10", n); end
    checks++;
    if (BUSY !== 1'b1 || IN_READY !== 1'b0) begin
      errors++; $display("FAIL c1_done_flags: busy=%b in_ready=%b required 1 0", BUSY, IN_READY);
    end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL c1_ct: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (CIPHERTEXT !== e) begin errors++; $display("FAIL c1_ct: got %h required %h", CIPHERTEXT, e); end
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL c1_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", OUT_VALID, IN_READY, BUSY);
    end
  endtask

  task automatic test_appb();
    bit ok;
    int n;
    logic [0:127] e;
    send_block(B_PT, B_KEY, B_CT, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL appb_accept: in_ready=%b required 1", IN_READY); end
    tick();
    checks++;
    if (dut.key_reg !== B_RK1) begin
      errors++; $display("FAIL appb_rk1: got %h required %h", dut.key_reg, B_RK1);
    end
    wait_out(n);
    checks++;
    if (n != 9) begin errors++; $display("FAIL appb_latency: got %0d edges required 9", n); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL appb_ct: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (CIPHERTEXT !== e) begin errors++; $display("FAIL appb_ct: got %h required %h", CIPHERTEXT, e); end
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [0:127] e;
    send_block(C1_PT, C1_KEY, C1_CT, ok);
    wait_out(n);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (n < 0 || CIPHERTEXT !== e) begin
      errors++; $display("FAIL bp_ct: got %h required %h (wait %0d)", CIPHERTEXT, e, n);
    end
    for (int i = 0; i < 20; i++) begin
      IN_VALID  = 1'(i % 2);
      PLAINTEXT = {$urandom(), $urandom(), $urandom(), $urandom()};
      KEY       = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      checks++;
      if (CIPHERTEXT !== C1_CT || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ct=%h out_valid=%b in_ready=%b required %h 1 0",
                 i, CIPHERTEXT, OUT_VALID, IN_READY, C1_CT);
      end
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", OUT_VALID, IN_READY);
    end
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL bp_no_ghost: busy=%b required 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int outs = 0;
    bit sw   = 1'b0;
    logic [0:127] e;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    PLAINTEXT = C1_PT;
    KEY       = C1_KEY;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(acc_cyc.size() == 0 ? C1_CT : B_CT);
        acc_cyc.push_back(cyc);
        sw = 1'b1;
      end
      if (OUT_VALID) begin
        outs++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_ct: unexpected output %h", CIPHERTEXT); end
        else begin
          e = exp_q.pop_front();
          if (CIPHERTEXT !== e) begin errors++; $display("FAIL b2b_ct: got %h required %h", CIPHERTEXT, e); end
        end
      end
      tick();
      if (sw) begin
        if (acc_cyc.size() == 1) begin
          PLAINTEXT = B_PT;
          KEY       = B_KEY;
        end else begin
          IN_VALID = 1'b0;
        end
        sw = 1'b0;
      end
    end
    OUT_READY = 1'b0;
    IN_VALID  = 1'b0;
    checks++;
    if (outs != 2) begin errors++; $display("FAIL b2b_count: got %0d outputs required 2", outs); end
    checks++;
    if (acc_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_spacing: got %0d accepts required 2", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != 12) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles required 12", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_churn();
    bit ok;
    int n = 0;
    logic [0:127] e;
    send_block(C1_PT, C1_KEY, C1_CT, ok);
    while (!OUT_VALID && n < 40) begin
      PLAINTEXT = {$urandom(), $urandom(), $urandom(), $urandom()};
      KEY       = {$urandom(), $urandom(), $urandom(), $urandom()};
      IN_VALID  = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    IN_VALID = 1'b0;
    checks++;
    if (n != 10) begin errors++; $display("FAIL churn_latency: got %0d edges required 10", n); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL churn_ct: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (CIPHERTEXT !== e) begin errors++; $display("FAIL churn_ct: got %h required %h", CIPHERTEXT, e); end
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    bit seen = 1'b0;
    logic [0:127] e;
    send_block(C1_PT, C1_KEY, C1_CT, ok);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (dut.rnd !== 4'd5) begin errors++; $display("FAIL mid_rnd: got %0d required 5", dut.rnd); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.delete();
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || BUSY !== 1'b0 || CIPHERTEXT !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b ct=%h required 1 0 0 0",
               IN_READY, OUT_VALID, BUSY, CIPHERTEXT);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (OUT_VALID) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_output: out_valid seen=1 required 0"); end
    send_block(C1_PT, C1_KEY, C1_CT, ok);
    wait_out(n);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL mid_rerun_ct: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if (n != 10 || CIPHERTEXT !== e) begin
        errors++; $display("FAIL mid_rerun_ct: got %h after %0d edges required %h after 10", CIPHERTEXT, n, e);
      end
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_c1();
    test_appb();
    test_backpressure();
    test_back_to_back();
    test_churn();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
